// File: rtl/draw_pkg.sv
// Shared definitions for the column frame renderer.
//   state_t       : renderer FSM states (IDLE, REQ, DRAW, DONE)
//   *_DEF         : default screen geometry and bus widths
//   BLACK / SKY   : common 3-bit palette constants
package draw_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DRAW = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int SCREEN_W_DEF = 160;
  localparam int SCREEN_H_DEF = 120;
  localparam int COLOR_W_DEF  = 3;
  localparam int XW_DEF       = 8;
  localparam int YW_DEF       = 7;
  localparam int SIZE_W_DEF   = 8;

  localparam logic [2:0] BLACK = 3'b000;
  localparam logic [2:0] SKY   = 3'b011;

endpackage

// File: rtl/column_frame_renderer_if.sv
// Slice-request and pixel-write bus of the column frame renderer.
//   col_req/col_idx            : renderer -> ray-caster slice request
//   slice_valid/size/color     : ray-caster -> renderer slice data
//   pix_we/pix_x/pix_y/pix_color : renderer -> frame-buffer write port
//   pix_ready                  : frame-buffer back-pressure (PIX_READY_EN only)
// Modports: master = renderer side, slave = ray-caster / frame-buffer side.
interface column_frame_renderer_if #(
  parameter int XW      = 8,
  parameter int YW      = 7,
  parameter int COLOR_W = 3,
  parameter int SIZE_W  = 8
) ();

  logic               col_req;
  logic [XW-1:0]      col_idx;
  logic               slice_valid;
  logic [SIZE_W-1:0]  slice_size;
  logic [COLOR_W-1:0] slice_color;
  logic               pix_we;
  logic [XW-1:0]      pix_x;
  logic [YW-1:0]      pix_y;
  logic [COLOR_W-1:0] pix_color;
`ifdef PIX_READY_EN
  logic               pix_ready;

  modport master (
    output col_req, col_idx, pix_we, pix_x, pix_y, pix_color,
    input  slice_valid, slice_size, slice_color, pix_ready
  );

  modport slave (
    input  col_req, col_idx, pix_we, pix_x, pix_y, pix_color,
    output slice_valid, slice_size, slice_color, pix_ready
  );
`else
  modport master (
    output col_req, col_idx, pix_we, pix_x, pix_y, pix_color,
    input  slice_valid, slice_size, slice_color
  );

  modport slave (
    input  col_req, col_idx, pix_we, pix_x, pix_y, pix_color,
    output slice_valid, slice_size, slice_color
  );
`endif

endinterface

// File: rtl/column_frame_renderer_span_gen.sv
// column_span_gen: per-column row walker.
// Owns the row counter, the clamped wall size, the wall top row and the wall
// colour; selects ceiling/wall/floor colour for the current row.
//   clock, resetn   : clock, synchronous active-low reset
//   load_i          : slice accepted; latch size/colour, restart at row 0
//   step_i          : advance one row (ignored on the last row)
//   slice_size_i/slice_color_i : slice data from the ray-caster
//   ceil_color_i/floor_color_i : frame colours (already latched upstream)
//   y_o, color_o    : current row and its colour
//   last_o          : current row is SCREEN_H-1
module column_span_gen #(
  parameter int SCREEN_H = 120,
  parameter int COLOR_W  = 3,
  parameter int YW       = 7,
  parameter int SIZE_W   = 8
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               load_i,
  input  logic               step_i,
  input  logic [SIZE_W-1:0]  slice_size_i,
  input  logic [COLOR_W-1:0] slice_color_i,
  input  logic [COLOR_W-1:0] ceil_color_i,
  input  logic [COLOR_W-1:0] floor_color_i,
  output logic [YW-1:0]      y_o,
  output logic [COLOR_W-1:0] color_o,
  output logic               last_o
);

  // One extra bit so top+sz == SCREEN_H never wraps.
  localparam int SZW = YW + 1;

  logic [YW-1:0]      y_q, y_d;
  logic [YW-1:0]      top_q, top_d;
  logic [SZW-1:0]     sz_q, sz_d;
  logic [COLOR_W-1:0] wall_q, wall_d;

  logic [SIZE_W-1:0]  sz_clamp;
  logic [SZW-1:0]     gap;
  logic [SZW-1:0]     y_ext, top_ext, end_ext;

  assign last_o = (y_q == YW'(SCREEN_H - 1));
  assign y_o    = y_q;

  always_comb begin
    sz_clamp = (slice_size_i > SIZE_W'(SCREEN_H)) ? SIZE_W'(SCREEN_H) : slice_size_i;
    gap      = SZW'(SCREEN_H) - SZW'(sz_clamp);
    y_d      = y_q;
    top_d    = top_q;
    sz_d     = sz_q;
    wall_d   = wall_q;
    if (load_i) begin
      y_d    = '0;
      sz_d   = SZW'(sz_clamp);
      // Floor of the halved gap: an odd leftover row lands below the wall.
      top_d  = gap[SZW-1:1];
      wall_d = slice_color_i;
    end else if (step_i && !last_o) begin
      y_d = y_q + YW'(1);
    end
  end

  always_comb begin
    y_ext   = {1'b0, y_q};
    top_ext = {1'b0, top_q};
    end_ext = top_ext + sz_q;
    if (y_ext < top_ext)
      color_o = ceil_color_i;
    else if (y_ext < end_ext)
      color_o = wall_q;
    else
      color_o = floor_color_i;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      y_q    <= '0;
      top_q  <= '0;
      sz_q   <= '0;
      wall_q <= '0;
    end else begin
      y_q    <= y_d;
      top_q  <= top_d;
      sz_q   <= sz_d;
      wall_q <= wall_d;
    end
  end

endmodule

// File: rtl/column_frame_renderer.sv
// column_frame_renderer: draws a full frame column by column (no clear pass).
// Per column: request a slice, then write every row (ceiling, wall, floor).
// Optional macro PIX_READY_EN adds pix_ready back-pressure on the pixel bus.
//   clock, resetn            : clock, synchronous active-low reset
//   frame_start              : start request, sampled only in IDLE
//   ceil_color, floor_color  : frame colours, latched on frame accept
//   bus (master modport)     : slice request + pixel write bus
//   frame_busy               : high from frame accept until DONE exits
//   frame_done               : one-cycle end-of-frame pulse
// All outputs are registered; pixel outputs lag the DRAW row by one cycle.
module column_frame_renderer
  import draw_pkg::*;
#(
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF,
  parameter int COLOR_W  = COLOR_W_DEF,
  parameter int XW       = XW_DEF,
  parameter int YW       = YW_DEF,
  parameter int SIZE_W   = SIZE_W_DEF
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic                    frame_start,
  input  logic [COLOR_W-1:0]      ceil_color,
  input  logic [COLOR_W-1:0]      floor_color,
  column_frame_renderer_if.master bus,
  output logic                    frame_busy,
  output logic                    frame_done
);

  localparam logic [XW-1:0] LAST_COL = XW'(SCREEN_W - 1);

  state_t state_q, state_d;

  logic               col_req_q, col_req_d;
  logic [XW-1:0]      col_idx_q, col_idx_d;
  logic               pix_we_q, pix_we_d;
  logic [XW-1:0]      pix_x_q, pix_x_d;
  logic [YW-1:0]      pix_y_q, pix_y_d;
  logic [COLOR_W-1:0] pix_color_q, pix_color_d;
  logic               frame_busy_q, frame_busy_d;
  logic               frame_done_q, frame_done_d;
  logic [COLOR_W-1:0] ceil_q, ceil_d;
  logic [COLOR_W-1:0] floor_q, floor_d;

  logic               accept;
  logic               stall;
  logic               span_step;
  logic               span_last;
  logic [YW-1:0]      span_y;
  logic [COLOR_W-1:0] span_color;

  assign accept = (state_q == REQ) && col_req_q && bus.slice_valid;

`ifdef PIX_READY_EN
  // A presented pixel that is not taken freezes the whole pixel pipeline.
  assign stall = pix_we_q && !bus.pix_ready;
`else
  assign stall = 1'b0;
`endif

  assign span_step = (state_q == DRAW) && !stall;

  column_span_gen #(
    .SCREEN_H (SCREEN_H),
    .COLOR_W  (COLOR_W),
    .YW       (YW),
    .SIZE_W   (SIZE_W)
  ) u_span (
    .clock         (clock),
    .resetn        (resetn),
    .load_i        (accept),
    .step_i        (span_step),
    .slice_size_i  (bus.slice_size),
    .slice_color_i (bus.slice_color),
    .ceil_color_i  (ceil_q),
    .floor_color_i (floor_q),
    .y_o           (span_y),
    .color_o       (span_color),
    .last_o        (span_last)
  );

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (frame_start) state_d = REQ;
      REQ:  if (accept) state_d = DRAW;
      DRAW: if (!stall && span_last) state_d = (col_idx_q == LAST_COL) ? DONE : REQ;
      DONE: if (!stall) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath next values.
  always_comb begin
    col_req_d    = (state_d == REQ);
    col_idx_d    = col_idx_q;
    frame_busy_d = frame_busy_q;
    frame_done_d = (state_q == DONE) && !stall;
    ceil_d       = ceil_q;
    floor_d      = floor_q;
    pix_we_d     = pix_we_q;
    pix_x_d      = pix_x_q;
    pix_y_d      = pix_y_q;
    pix_color_d  = pix_color_q;

    case (state_q)
      IDLE: begin
        if (frame_start) begin
          col_idx_d    = '0;
          frame_busy_d = 1'b1;
          ceil_d       = ceil_color;
          floor_d      = floor_color;
        end
      end
      DRAW: begin
        if (!stall && span_last && (col_idx_q != LAST_COL))
          col_idx_d = col_idx_q + XW'(1);
      end
      DONE: begin
        if (!stall) frame_busy_d = 1'b0;
      end
      default: ;
    endcase

    if (!stall) begin
      pix_we_d = (state_q == DRAW);
      if (state_q == DRAW) begin
        pix_x_d     = col_idx_q;
        pix_y_d     = span_y;
        pix_color_d = span_color;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q      <= IDLE;
      col_req_q    <= 1'b0;
      col_idx_q    <= '0;
      pix_we_q     <= 1'b0;
      pix_x_q      <= '0;
      pix_y_q      <= '0;
      pix_color_q  <= '0;
      frame_busy_q <= 1'b0;
      frame_done_q <= 1'b0;
      ceil_q       <= COLOR_W'(BLACK);
      floor_q      <= COLOR_W'(BLACK);
    end else begin
      state_q      <= state_d;
      col_req_q    <= col_req_d;
      col_idx_q    <= col_idx_d;
      pix_we_q     <= pix_we_d;
      pix_x_q      <= pix_x_d;
      pix_y_q      <= pix_y_d;
      pix_color_q  <= pix_color_d;
      frame_busy_q <= frame_busy_d;
      frame_done_q <= frame_done_d;
      ceil_q       <= ceil_d;
      floor_q      <= floor_d;
    end
  end

  assign bus.col_req   = col_req_q;
  assign bus.col_idx   = col_idx_q;
  assign bus.pix_we    = pix_we_q;
  assign bus.pix_x     = pix_x_q;
  assign bus.pix_y     = pix_y_q;
  assign bus.pix_color = pix_color_q;
  assign frame_busy    = frame_busy_q;
  assign frame_done    = frame_done_q;

endmodule
